// File: rtl/nv_dw_minmax_unpool.sv
// Streaming min/max un-pooler: expands one (value, index, min_max) token into num_inputs serial beats.
// Optional macro NV_DW_UNPOOL_IDX_CHK_EN clamps out-of-range indices and raises the sticky idx_err flag.
module nv_dw_minmax_unpool #(
  parameter int width = 8,
  parameter int num_inputs = 4,
  localparam int index_width = $clog2(num_inputs)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [width-1:0]       in_value,
  input  logic [index_width-1:0] in_index,
  input  logic                   in_min_max,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [width-1:0]       out_data,
  output logic [index_width-1:0] out_pos,
  output logic                   out_last,
  output logic                   idx_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [index_width:0] last_cnt = (index_width + 1)'(num_inputs - 1);

  state_t                 state_r, state_s;
  logic [width-1:0]       val_r, val_s;
  logic [index_width-1:0] idx_r, idx_s, idx_cap_s;
  logic                   mm_r, mm_s;
  logic [index_width:0]   cnt_r, cnt_s;
  logic                   idx_err_r, idx_err_s;
  logic                   beat_done_s, in_prdy_s, take_s;
  logic                   out_pvld_r, out_last_r;
  logic [width-1:0]       out_data_r, data_s;
  logic [index_width-1:0] out_pos_r, pos_s;
  logic                   last_s;
`ifdef NV_DW_UNPOOL_IDX_CHK_EN
  logic                   idx_bad_s;
`endif

  function automatic logic [width-1:0] beat_data(
    input logic [width-1:0]       val,
    input logic [index_width-1:0] idx,
    input logic                   mm,
    input logic [index_width:0]   cnt
  );
    logic [width-1:0] res;
    if (cnt == {1'b0, idx}) begin
      res = val;
    end else if (mm) begin
      res = {width{1'b0}};
    end else begin
      res = {width{1'b1}};
    end
    return res;
  endfunction

  // Index range check and clamp applied at token capture
  always_comb begin
`ifdef NV_DW_UNPOOL_IDX_CHK_EN
    idx_bad_s = ({1'b0, in_index} > last_cnt);
    if (idx_bad_s) begin
      idx_cap_s = last_cnt[index_width-1:0];
    end else begin
      idx_cap_s = in_index;
    end
`else
    idx_cap_s = in_index;
`endif
  end

  // Next-state logic: token capture, beat advance and the precomputed next beat
  always_comb begin
    state_s   = state_r;
    val_s     = val_r;
    idx_s     = idx_r;
    mm_s      = mm_r;
    cnt_s     = cnt_r;
    idx_err_s = idx_err_r;
    beat_done_s = (state_r == EMIT) && out_prdy;
    // ready reopens on the accepted last beat so the next window follows without a bubble
    in_prdy_s = nvdla_core_rstn && ((state_r == IDLE) || (beat_done_s && out_last_r));
    take_s    = in_prdy_s && in_pvld;

    case (state_r)
      IDLE: state_s = take_s ? EMIT : IDLE;
      EMIT: begin
        if (!beat_done_s) begin
          state_s = EMIT;
        end else if (out_last_r) begin
          state_s = take_s ? EMIT : IDLE;
        end else begin
          state_s = EMIT;
          cnt_s   = cnt_r + {{index_width{1'b0}}, 1'b1};
        end
      end
      default: state_s = IDLE;
    endcase

    if (take_s) begin
      val_s = in_value;
      idx_s = idx_cap_s;
      mm_s  = in_min_max;
      cnt_s = {(index_width + 1){1'b0}};
`ifdef NV_DW_UNPOOL_IDX_CHK_EN
      idx_err_s = idx_err_r | idx_bad_s;
`endif
    end else begin
      val_s = val_r;
    end

`ifndef NV_DW_UNPOOL_IDX_CHK_EN
    idx_err_s = 1'b0;
`endif

    if (state_s == EMIT) begin
      data_s = beat_data(val_s, idx_s, mm_s, cnt_s);
      pos_s  = cnt_s[index_width-1:0];
      last_s = (cnt_s == last_cnt);
    end else begin
      data_s = {width{1'b0}};
      pos_s  = {index_width{1'b0}};
      last_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Captured token, beat counter and sticky index error
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      val_r     <= {width{1'b0}};
      idx_r     <= {index_width{1'b0}};
      mm_r      <= 1'b0;
      cnt_r     <= {(index_width + 1){1'b0}};
      idx_err_r <= 1'b0;
    end else begin
      val_r     <= val_s;
      idx_r     <= idx_s;
      mm_r      <= mm_s;
      cnt_r     <= cnt_s;
      idx_err_r <= idx_err_s;
    end
  end

  // Registered beat outputs
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pvld_r <= 1'b0;
      out_data_r <= {width{1'b0}};
      out_pos_r  <= {index_width{1'b0}};
      out_last_r <= 1'b0;
    end else begin
      out_pvld_r <= (state_s == EMIT);
      out_data_r <= data_s;
      out_pos_r  <= pos_s;
      out_last_r <= last_s;
    end
  end

  assign in_prdy  = in_prdy_s;
  assign out_pvld = out_pvld_r;
  assign out_data = out_data_r;
  assign out_pos  = out_pos_r;
  assign out_last = out_last_r;
  assign idx_err  = idx_err_r;

endmodule
